vend_controller: RTL and testbench

Sequencing FSM for the vending machine. It accepts coins, holds the customer credit, checks a purchase request against price and stock, then issues one dispense pulse per item and returns the change. It sits between the customer-facing inputs (mode, in_money, type, number) and the dispenser/coin-return hardware. It owns the per-product stock counters.

---
 rtl/vend_controller.sv | 164 ++++++++++++++++
 tb/tb_vend_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending machine sequencer: coin collection, price/stock check, per-item
// dispense pulses and change return. Owns the two product stock counters.
module vend_controller #(
  parameter int unsigned PRICE0     = 3,
  parameter int unsigned PRICE1     = 5,
  parameter int unsigned STOCK_INIT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       coin_valid,
  input  logic [3:0] in_money,
  input  logic       item_type,
  input  logic [1:0] number,
  input  logic       buy,
  input  logic       cancel,
  output logic [4:0] credit,
  output logic       dispense,
  output logic       disp_type,
  output logic [4:0] change,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       err_money,
  output logic       err_stock,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, DISPENSE, CHANGE} state_t;

  localparam logic [2:0] STOCK_FULL = 3'(STOCK_INIT);

  state_t     state, state_n;
  logic [4:0] credit_n, change_n;
  logic [2:0] stock0, stock1, stock0_n, stock1_n, stock_sel;
  logic       type_q, type_n;
  logic [1:0] num_q, num_n, cnt, cnt_n;
  logic       disp_n, dtype_n, cv_n, cr_n, em_n, es_n, busy_n;
  logic [5:0] sum;
  logic [6:0] cost;

  assign sum       = {1'b0, credit} + {2'b00, in_money};
  assign cost      = (type_q ? 7'(PRICE1) : 7'(PRICE0)) * {5'b00000, num_q};
  assign stock_sel = type_q ? stock1 : stock0;

  // Outputs are next-state values registered alongside the state, so the
  // first dispense pulse is issued by the edge that leaves CHECK.
  always_comb begin
    state_n  = state;
    credit_n = credit;
    stock0_n = stock0;
    stock1_n = stock1;
    type_n   = type_q;
    num_n    = num_q;
    cnt_n    = cnt;
    disp_n   = 1'b0;
    dtype_n  = 1'b0;
    change_n = '0;
    cv_n     = 1'b0;
    cr_n     = 1'b0;
    em_n     = 1'b0;
    es_n     = 1'b0;
    case (state)
      IDLE: begin
        if (!mode) begin
          stock0_n = STOCK_FULL;
          stock1_n = STOCK_FULL;
          cr_n     = coin_valid;
        end else if (coin_valid) begin
          credit_n = {1'b0, in_money};
          state_n  = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          change_n = credit;
          cv_n     = 1'b1;
          credit_n = '0;
          cr_n     = coin_valid;
          state_n  = IDLE;
        end else if (buy) begin
          type_n  = item_type;
          num_n   = number;
          cr_n    = coin_valid;
          state_n = CHECK;
        end else if (coin_valid) begin
          if (sum <= 6'd31) credit_n = sum[4:0];
          else              cr_n     = 1'b1;
        end
      end
      CHECK: begin
        cr_n = coin_valid;
        if (num_q == 2'd0 || stock_sel < {1'b0, num_q}) begin
          es_n    = 1'b1;
          state_n = COLLECT;
        end else if ({2'b00, credit} < cost) begin
          em_n    = 1'b1;
          state_n = COLLECT;
        end else begin
          disp_n  = 1'b1;
          dtype_n = type_q;
          if (type_q) stock1_n = stock1 - 3'd1;
          else        stock0_n = stock0 - 3'd1;
          cnt_n   = num_q - 2'd1;
          state_n = (num_q == 2'd1) ? CHANGE : DISPENSE;
        end
      end
      DISPENSE: begin
        cr_n    = coin_valid;
        disp_n  = 1'b1;
        dtype_n = type_q;
        if (type_q) stock1_n = stock1 - 3'd1;
        else        stock0_n = stock0 - 3'd1;
        cnt_n   = cnt - 2'd1;
        if (cnt == 2'd1) state_n = CHANGE;
      end
      CHANGE: begin
        cr_n     = coin_valid;
        change_n = credit - cost[4:0];
        cv_n     = 1'b1;
        credit_n = '0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == CHECK) || (state_n == DISPENSE) || (state_n == CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      stock0       <= STOCK_FULL;
      stock1       <= STOCK_FULL;
      type_q       <= 1'b0;
      num_q        <= '0;
      cnt          <= '0;
      dispense     <= 1'b0;
      disp_type    <= 1'b0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      err_money    <= 1'b0;
      err_stock    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      stock0       <= stock0_n;
      stock1       <= stock1_n;
      type_q       <= type_n;
      num_q        <= num_n;
      cnt          <= cnt_n;
      dispense     <= disp_n;
      disp_type    <= dtype_n;
      change       <= change_n;
      change_valid <= cv_n;
      coin_reject  <= cr_n;
      err_money    <= em_n;
      err_stock    <= es_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios followed by random
// traffic, checked against a transaction-level model of credit and stock.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b1;
  logic       coin_valid = 1'b0;
  logic [3:0] in_money = '0;
  logic       item_type = 1'b0;
  logic [1:0] number = '0;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic [4:0] credit, change;
  logic       dispense, disp_type, change_valid, coin_reject, err_money, err_stock, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: credit held, whether a session (coins accepted) is open, stock levels.
  int m_credit = 0;
  bit m_open = 0;
  int m_stock[2] = '{7, 7};
  int price[2] = '{3, 5};

  vend_controller #(.PRICE0(3), .PRICE1(5), .STOCK_INIT(7)) dut (
    .clk(clk), .reset(reset), .mode(mode), .coin_valid(coin_valid),
    .in_money(in_money), .item_type(item_type), .number(number), .buy(buy),
    .cancel(cancel), .credit(credit), .dispense(dispense), .disp_type(disp_type),
    .change(change), .change_valid(change_valid), .coin_reject(coin_reject),
    .err_money(err_money), .err_stock(err_stock), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int ec, input bit ed, input bit edt,
                     input int ech, input bit ecv, input bit ecr, input bit eem,
                     input bit ees, input bit eb);
    logic [16:0] obs, exp;
    exp = {ec[4:0], ed, edt, ech[4:0], ecv, ecr, eem, ees, eb};
    obs = {credit, dispense, disp_type, change, change_valid, coin_reject,
           err_money, err_stock, busy};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h {credit,disp,dtype,change,cv,crej,emon,estk,busy}",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    coin_valid = 1'b0;
    buy        = 1'b0;
    cancel     = 1'b0;
    in_money   = '0;
  endtask

  // Effect of one edge seen while no session is open or in a collecting session.
  task automatic model_coin(input bit has_coin, input int v, output bit rej);
    rej = 0;
    if (!m_open && !mode) m_stock = '{7, 7};
    if (!has_coin) return;
    if (!m_open) begin
      if (!mode) rej = 1;
      else begin
        m_credit = v;
        m_open   = 1;
      end
    end else if (m_credit + v <= 31) m_credit += v;
    else rej = 1;
  endtask

  task automatic idle_step(input string tag);
    bit rej;
    clr();
    tick();
    model_coin(0, 0, rej);
    chk(tag, m_credit, 0, 0, 0, 0, rej, 0, 0, 0);
  endtask

  task automatic coin(input string tag, input int v);
    bit rej;
    clr();
    coin_valid = 1'b1;
    in_money   = 4'(v);
    tick();
    clr();
    model_coin(1, v, rej);
    chk(tag, m_credit, 0, 0, 0, 0, rej, 0, 0, 0);
  endtask

  task automatic cancel_op(input string tag, input bit with_coin);
    bit rej;
    int v;
    v = $urandom_range(0, 15);
    clr();
    cancel     = 1'b1;
    coin_valid = with_coin;
    in_money   = 4'(v);
    tick();
    clr();
    if (m_open) begin
      chk(tag, 0, 0, 0, m_credit, 1, with_coin, 0, 0, 0);
      m_credit = 0;
      m_open   = 0;
    end else begin
      model_coin(with_coin, v, rej);
      chk(tag, m_credit, 0, 0, 0, 0, rej, 0, 0, 0);
    end
  endtask

  // coin_at: cycle index relative to the buy edge carrying a coin strobe (-1 none).
  task automatic buy_op(input string tag, input int t, input int n, input int coin_at);
    bit rej;
    int v, cost;
    v = $urandom_range(0, 15);
    clr();
    buy        = 1'b1;
    item_type  = t[0];
    number     = 2'(n);
    coin_valid = (coin_at == 0);
    in_money   = 4'(v);
    tick();
    clr();
    if (!m_open) begin
      model_coin(coin_at == 0, v, rej);
      chk({tag, ".ign"}, m_credit, 0, 0, 0, 0, rej, 0, 0, 0);
      return;
    end
    chk({tag, ".buy"}, m_credit, 0, 0, 0, 0, coin_at == 0, 0, 0, 1);
    coin_valid = (coin_at == 1);
    in_money   = 4'($urandom_range(0, 15));
    tick();
    clr();
    cost = price[t] * n;
    if (n == 0 || m_stock[t] < n) begin
      chk({tag, ".estk"}, m_credit, 0, 0, 0, 0, coin_at == 1, 0, 1, 0);
      return;
    end
    if (m_credit < cost) begin
      chk({tag, ".emon"}, m_credit, 0, 0, 0, 0, coin_at == 1, 1, 0, 0);
      return;
    end
    for (int i = 1; i <= n + 1; i++) begin
      if (i > 1) begin
        coin_valid = (coin_at == i);
        in_money   = 4'($urandom_range(0, 15));
        tick();
        clr();
      end
      if (i <= n) chk({tag, ".disp"}, m_credit, 1, t[0], 0, 0, coin_at == i, 0, 0, 1);
      else        chk({tag, ".chg"}, 0, 0, 0, m_credit - cost, 1, coin_at == i, 0, 0, 0);
    end
    m_stock[t] -= n;
    m_credit = 0;
    m_open   = 0;
  endtask

  initial begin
    clr();
    mode  = 1'b1;
    reset = 1'b1;
    #13;
    chk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic purchase: 9+4 = 13, two of product 0 cost 6, change 7.
    coin("coin9", 9);
    coin("coin4", 4);
    buy_op("buy0x2", 0, 2, -1);

    // Insufficient credit then top-up.
    coin("coin4b", 4);
    buy_op("buy1x1_poor", 1, 1, -1);
    coin("coin1", 1);
    buy_op("buy1x1", 1, 1, -1);

    // Stock errors and draining product 1, then a maintenance reload.
    coin("coin15", 15);
    buy_op("buy_n0", 0, 0, -1);
    buy_op("drain1a", 1, 3, -1);
    coin("coin15b", 15);
    buy_op("drain1b", 1, 3, -1);
    coin("coin5", 5);
    buy_op("buy_empty", 1, 1, -1);
    cancel_op("cancel5", 0);
    mode = 1'b0;
    idle_step("maint");
    coin("coin_maint", 3);
    mode = 1'b1;
    coin("coin5b", 5);
    buy_op("buy_after_reload", 1, 1, -1);

    // Credit overflow, and a coin that collides with buy.
    coin("coin15c", 15);
    coin("coin15d", 15);
    coin("coin_over", 5);
    buy_op("buy_coin_same", 0, 1, 0);

    // Cancel, zero-value coin, and a coin during dispensing.
    coin("coin9b", 9);
    cancel_op("cancel9", 0);
    coin("coin0", 0);
    cancel_op("cancel0", 1);
    coin("coin15e", 15);
    buy_op("buy_coin_disp", 0, 3, 2);

    // Idle-state buy/cancel are ignored.
    buy_op("idle_buy", 0, 1, -1);
    cancel_op("idle_cancel", 0);

    // Reset mid-dispense with product 0 stock at 3 beforehand.
    coin("coin15f", 15);
    clr();
    buy = 1'b1; item_type = 1'b0; number = 2'd3;
    tick();
    clr();
    chk("rst.buy", 15, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("rst.disp1", 15, 1, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    #1;
    chk("rst.async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_credit = 0;
    m_open   = 0;
    m_stock  = '{7, 7};
    @(negedge clk);
    reset = 1'b0;
    coin("coin15g", 15);
    buy_op("buy_after_rst", 0, 3, -1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      int r, n;
      r = $urandom_range(0, 9);
      if (r <= 3) coin("r.coin", $urandom_range(0, 15));
      else if (r <= 6) begin
        n = $urandom_range(0, 3);
        buy_op("r.buy", $urandom_range(0, 1), n, int'($urandom_range(0, n + 2)) - 1);
      end else if (r == 7) cancel_op("r.cancel", $urandom_range(0, 1) == 1);
      else if (r == 8) idle_step("r.idle");
      else mode = ($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
